vec_addsub_sequencer: RTL

- Upstream control stage for the execute-stage combinational adder/subtractor.
- Accepts one vector operation (LANES lanes of WIDTH bits, add or subtract) over a valid/ready handshake.
- Drives the shared adder one lane per cycle and captures each lane's sum, carry and overflow into result registers.
- Presents the packed result vector and per-lane flags to writeback over a second valid/ready handshake.

---
 rtl/vec_addsub_sequencer_if.sv | 34 +++
 rtl/vec_addsub_sequencer.sv | 112 +++++++++++
 2 files changed

// File: rtl/vec_addsub_sequencer_if.sv
// Request/result handshake bundle between the vector add/sub sequencer,
// its requester (in_*) and the writeback consumer (out_*).
interface vec_addsub_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
);

  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_a;
  logic [LANES*WIDTH-1:0] in_b;
  logic                   in_sub;

  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_s;
  logic [LANES-1:0]       out_c;
  logic [LANES-1:0]       out_v;
  logic [LANES-1:0]       out_z;
  logic                   out_any_v;

  // Requester/consumer side.
  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_s, out_c, out_v, out_z, out_any_v
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_s, out_c, out_v, out_z, out_any_v
  );

endinterface

// File: rtl/vec_addsub_sequencer.sv
// Vector add/sub sequencer: accepts one LANES x WIDTH operation, walks the
// shared combinational adder one lane per cycle, collects sum/carry/overflow
// per lane and hands the packed result to writeback.
module vec_addsub_sequencer #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  vec_addsub_sequencer_if.slave io,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic                 add_subs,
  input  logic [WIDTH-1:0]     add_s,
  input  logic                 add_cout,
  input  logic                 add_v
);

  localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [IDXW-1:0]   idx;
  logic [IDXW-1:0]   nextIdx;
  logic              lastLane;

  logic [WIDTH-1:0]  opA [LANES];
  logic [WIDTH-1:0]  opB [LANES];

  assign lastLane = (idx == IDXW'(LANES - 1));
  assign nextIdx  = idx + 1'b1;

  // Summary overflow is a pure function of the registered per-lane flags.
  assign io.out_any_v = |io.out_v;

  // Capture the operand vectors on the accept edge.
  // NOTE: operand registers have no reset; they are always loaded on accept
  // before anything reads them, so a reset would only cost routing.
  always_ff @(posedge clk) begin
    if (state == IDLE && io.in_valid) begin
      for (int k = 0; k < LANES; k++) begin
        opA[k] <= io.in_a[k*WIDTH +: WIDTH];
        opB[k] <= io.in_b[k*WIDTH +: WIDTH];
      end
    end
  end

  // Control FSM with registered handshake, adder-drive and result outputs.
  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      io.in_ready  <= 1'b1;
      io.out_valid <= 1'b0;
      io.out_s     <= '0;
      io.out_c     <= '0;
      io.out_v     <= '0;
      io.out_z     <= '0;
      add_a        <= '0;
      add_b        <= '0;
      add_subs     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            state       <= RUN;
            idx         <= '0;
            io.in_ready <= 1'b0;
            // Lane 0 goes straight from the request bus; operand registers
            // are only being written on this same edge.
            add_a       <= io.in_a[WIDTH-1:0];
            add_b       <= io.in_b[WIDTH-1:0];
            add_subs    <= io.in_sub;
          end
        end

        RUN: begin
          io.out_s[idx*WIDTH +: WIDTH] <= add_s;
          io.out_c[idx]                <= add_cout;
          io.out_v[idx]                <= add_v;
          io.out_z[idx]                <= (add_s == '0);
          if (lastLane) begin
            state        <= DONE;
            idx          <= '0;
            io.out_valid <= 1'b1;
            add_a        <= '0;
            add_b        <= '0;
            add_subs     <= 1'b0;
          end else begin
            idx   <= nextIdx;
            add_a <= opA[nextIdx];
            add_b <= opB[nextIdx];
          end
        end

        DONE: begin
          if (io.out_ready) begin
            state        <= IDLE;
            io.out_valid <= 1'b0;
            io.in_ready  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
